mgr_mwc_pkt_writer: RTL

- Consumes the registered NoC data-path packet stream that the manager controller forwards to the memory write controller (MWC).
- Buffers incoming words, parses a header, and filters packets by manager ID.
- Writes payload words to the manager memory write port at incrementing addresses and reports completion and errors.
- Sits directly downstream of the manager controller's MWC output and upstream of the manager memory write port.

---
 rtl/mgr_mwc_pkt_writer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mgr_mwc_pkt_writer.sv
// Memory write controller packet writer: buffers the manager-controller stream,
// filters packets by manager ID and writes payload words to consecutive memory addresses.
module mgr_mwc_pkt_writer #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 24,
    parameter int MGRID_W     = 6,
    parameter int CNTL_W      = 2,
    parameter int TYPE_W      = 2,
    parameter int PTYPE_W     = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int READY_SLACK = 4
) (
    input  logic               clk,
    input  logic               reset_poweron,
    input  logic               mcntl__mwc__valid,
    input  logic [CNTL_W-1:0]  mcntl__mwc__cntl,
    input  logic [TYPE_W-1:0]  mcntl__mwc__type,
    input  logic [PTYPE_W-1:0] mcntl__mwc__ptype,
    input  logic [DATA_W-1:0]  mcntl__mwc__data,
    input  logic               mcntl__mwc__pvalid,
    input  logic [MGRID_W-1:0] mcntl__mwc__mgrId,
    output logic               mwc__mcntl__ready,
    input  logic               mcntl__mwc__flush,
    input  logic [MGRID_W-1:0] sys__mgr__mgrId,
    output logic               mwc__mem__wr_en,
    output logic [ADDR_W-1:0]  mwc__mem__wr_addr,
    output logic [DATA_W-1:0]  mwc__mem__wr_data,
    input  logic               mem__mwc__wr_ready,
    output logic               mwc__mcntl__pkt_done,
    output logic [7:0]         mwc__mcntl__drop_count,
    output logic [2:0]         mwc__mcntl__err
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = CNTL_W + TYPE_W + PTYPE_W + DATA_W + 1 + MGRID_W;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  SLACK_C   = CNT_W'(READY_SLACK);
    localparam logic [CNTL_W-1:0] C_SOM_EOM = CNTL_W'(0);
    localparam logic [CNTL_W-1:0] C_SOM     = CNTL_W'(1);
    localparam logic [CNTL_W-1:0] C_EOM     = CNTL_W'(3);

    typedef enum logic [1:0] {IDLE, DATA, DISCARD} state_t;

    state_t              state, next_state;
    logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr, rptr;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                stg_vld_p0;
    logic [WORD_W-1:0]   stg_word_p0;
    logic [ADDR_W-1:0]   addr, next_addr;
    logic [15:0]         exp_cnt, next_exp;
    logic [15:0]         wcnt, next_wcnt;
    logic                done_pend, done_bad, flush_pend;

    logic [CNTL_W-1:0]   s_cntl;
    logic [TYPE_W-1:0]   s_type;
    logic [PTYPE_W-1:0]  s_ptype;
    logic [DATA_W-1:0]   s_data;
    logic                s_pvalid;
    logic [MGRID_W-1:0]  s_mgrid;
    logic                unused_fields;

    logic wr_busy, wr_accept, flush_act, proc, push_req, push, pop, overflow;
    logic issue, done_now, arm_done, arm_bad, len_err, proto_err, drop_inc;

    assign {s_cntl, s_type, s_ptype, s_data, s_pvalid, s_mgrid} = stg_word_p0;
    assign unused_fields = ^{s_type, s_ptype};

    assign wr_busy   = mwc__mem__wr_en && !mem__mwc__wr_ready;
    assign wr_accept = mwc__mem__wr_en && mem__mwc__wr_ready;
    assign flush_act = (mcntl__mwc__flush || flush_pend) && !wr_busy;
    // Header/payload handling waits for a free write slot and for any EOM write to land.
    assign proc      = stg_vld_p0 && !wr_busy && !done_pend && !mcntl__mwc__flush && !flush_pend;
    assign push_req  = mcntl__mwc__valid && !mcntl__mwc__flush && !flush_pend;
    assign overflow  = push_req && (cnt == DEPTH_C);
    assign push      = push_req && (cnt != DEPTH_C);
    assign pop       = (cnt != '0) && (!stg_vld_p0 || proc) && !mcntl__mwc__flush && !flush_pend;

    always_comb begin
        cnt_next = cnt;
        if (flush_act)
            cnt_next = '0;
        else if (push && !pop)
            cnt_next = cnt + CNT_W'(1);
        else if (!push && pop)
            cnt_next = cnt - CNT_W'(1);
    end

    always_comb begin
        next_state = state;
        next_addr  = addr;
        next_exp   = exp_cnt;
        next_wcnt  = wcnt;
        issue      = 1'b0;
        done_now   = 1'b0;
        arm_done   = 1'b0;
        arm_bad    = 1'b0;
        len_err    = 1'b0;
        proto_err  = 1'b0;
        drop_inc   = 1'b0;
        if (proc) begin
            if (s_cntl == C_SOM || s_cntl == C_SOM_EOM) begin
                proto_err = (state != IDLE);
                next_addr = s_data[ADDR_W-1:0];
                next_exp  = s_data[ADDR_W+15:ADDR_W];
                next_wcnt = '0;
                if (s_mgrid != sys__mgr__mgrId) begin
                    next_state = DISCARD;
                    drop_inc   = 1'b1;
                end else if (s_cntl == C_SOM_EOM) begin
                    next_state = IDLE;
                    done_now   = 1'b1;
                    len_err    = (s_data[ADDR_W+15:ADDR_W] != 16'd0);
                end else begin
                    next_state = DATA;
                end
            end else begin
                case (state)
                    IDLE: proto_err = 1'b1;
                    DATA: begin
                        if (s_pvalid) begin
                            issue     = 1'b1;
                            next_addr = addr + ADDR_W'(1);
                            next_wcnt = wcnt + 16'd1;
                        end
                        if (s_cntl == C_EOM) begin
                            next_state = IDLE;
                            if (s_pvalid) begin
                                arm_done = 1'b1;
                                arm_bad  = ((wcnt + 16'd1) != exp_cnt);
                            end else begin
                                done_now = 1'b1;
                                len_err  = (wcnt != exp_cnt);
                            end
                        end
                    end
                    default: if (s_cntl == C_EOM) next_state = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wptr] <= {mcntl__mwc__cntl, mcntl__mwc__type, mcntl__mwc__ptype,
                               mcntl__mwc__data, mcntl__mwc__pvalid, mcntl__mwc__mgrId};
    end

    // FIFO pointers, pop stage and packet FSM
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            stg_vld_p0  <= 1'b0;
            stg_word_p0 <= '0;
            addr        <= '0;
            exp_cnt     <= '0;
            wcnt        <= '0;
            done_pend   <= 1'b0;
            done_bad    <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (flush_act) begin
                state      <= IDLE;
                wptr       <= '0;
                rptr       <= '0;
                stg_vld_p0 <= 1'b0;
                done_pend  <= 1'b0;
                flush_pend <= 1'b0;
            end else begin
                state   <= next_state;
                addr    <= next_addr;
                exp_cnt <= next_exp;
                wcnt    <= next_wcnt;
                if (mcntl__mwc__flush)
                    flush_pend <= 1'b1;
                if (push)
                    wptr <= wptr + PTR_W'(1);
                if (pop) begin
                    rptr        <= rptr + PTR_W'(1);
                    stg_vld_p0  <= 1'b1;
                    stg_word_p0 <= fifo_mem[rptr];
                end else if (proc) begin
                    stg_vld_p0 <= 1'b0;
                end
                if (arm_done) begin
                    done_pend <= 1'b1;
                    done_bad  <= arm_bad;
                end else if (wr_accept) begin
                    done_pend <= 1'b0;
                end
            end
        end
    end

    // Registered outputs: write port, ready, status
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            mwc__mem__wr_en        <= 1'b0;
            mwc__mem__wr_addr      <= '0;
            mwc__mem__wr_data      <= '0;
            mwc__mcntl__ready      <= 1'b0;
            mwc__mcntl__pkt_done   <= 1'b0;
            mwc__mcntl__drop_count <= '0;
            mwc__mcntl__err        <= '0;
        end else begin
            mwc__mcntl__ready    <= ((DEPTH_C - cnt_next) >= SLACK_C);
            mwc__mcntl__pkt_done <= done_now || (done_pend && wr_accept && !flush_act);
            if (issue) begin
                mwc__mem__wr_en   <= 1'b1;
                mwc__mem__wr_addr <= addr;
                mwc__mem__wr_data <= s_data;
            end else if (wr_accept) begin
                mwc__mem__wr_en <= 1'b0;
            end
            if (drop_inc && mwc__mcntl__drop_count != 8'hFF)
                mwc__mcntl__drop_count <= mwc__mcntl__drop_count + 8'd1;
            if (overflow)
                mwc__mcntl__err[0] <= 1'b1;
            if (proto_err)
                mwc__mcntl__err[1] <= 1'b1;
            if (len_err || (done_pend && wr_accept && done_bad && !flush_act))
                mwc__mcntl__err[2] <= 1'b1;
        end
    end
endmodule
